code_decomp_fill: RTL and testbench
===================================

Name: code_decomp_fill

Overview:
- Refill-side decompressor between the instruction cache's memory-request port and program memory.
- On a cache miss it looks up the 16-bit code-table entry for the requested instruction word.
- The entry is expanded from an on-chip dictionary or fetched from the raw-instruction region; the 32-bit instruction is returned on the cache's request handshake.
- Read-only path; the dictionary is loaded by software through a write port.

Parameters:
- DICT_BITS, 6, log2 of dictionary depth (64 x 32-bit entries).
- TEXT_BASE, 32'h0000_0000, base byte address of uncompressed program space seen by the cache.
- CODE_BASE, 32'h0001_0000, base byte address of the packed code table.
- RAW_BASE, 32'h0002_0000, base byte address of the raw-instruction region.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  cache miss request; held until req_ready is seen.
- req_ready  out  1  one-cycle pulse; req_rdata valid in the same cycle.
- req_addr  in  32  requested byte address; bits [1:0] ignored.
- req_rdata  out  32  decompressed instruction.
- mem_valid  out  1  memory read request.
- mem_ready  in  1  memory read done; mem_rdata valid this cycle.
- mem_addr  out  32  word-aligned memory byte address.
- mem_rdata  in  32  memory read data.
- dict_we  in  1  dictionary write enable.
- dict_waddr  in  DICT_BITS  dictionary write index.
- dict_wdata  in  32  dictionary write data.
- cnt_dict  out  32  count of responses served from the dictionary, wraps.
- cnt_raw  out  32  count of responses served from the raw region, wraps.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; req_ready=0, req_rdata=0, mem_valid=0, mem_addr=0, cnt_dict=0, cnt_raw=0; code buffer invalid; dictionary contents not reset.
- Address decode:
  - w = (req_addr - TEXT_BASE) >> 2, modulo 2^32; no range error.
  - Code word address = CODE_BASE + ((w >> 1) << 2); halfword select w[0]: 0 = bits[15:0], 1 = bits[31:16].
  - Entry bit15=1: dictionary, index = entry[DICT_BITS-1:0].
  - Entry bit15=0: raw, address = RAW_BASE + (entry[14:0] << 2).
- FSM states:
  - IDLE: req_valid=1 -> latch req_addr, drive mem_addr=code word address, mem_valid=1 -> CODE.
  - CODE: hold mem_valid and mem_addr until mem_ready. On mem_ready: mem_valid=0, register the selected halfword -> DECODE.
  - DECODE, one cycle:
    - Dictionary entry: req_rdata = dict[index] -> RESP.
    - Raw entry: mem_addr = raw address, mem_valid=1 -> RAW.
  - RAW: on mem_ready: mem_valid=0, req_rdata=mem_rdata -> RESP.
  - RESP: req_ready=1 for exactly one cycle; increment cnt_dict or cnt_raw -> IDLE.
- Latency, zero-wait memory with mem_ready in the first mem_valid cycle: dictionary response 3 cycles after the IDLE accept edge; raw response 4 cycles after it.
- Memory handshake: mem_valid and mem_addr stable until mem_ready. Only one outstanding memory request.
- Abort: req_valid low in CODE or RAW -> finish the outstanding memory handshake, discard the data, no RESP, no counter change -> IDLE. req_valid low in DECODE -> IDLE.
- req_valid low in IDLE: no action. req_addr changes while busy are ignored (the latched copy is used).
- Dictionary write:
  - Allowed in any state; takes effect at the edge.
  - A DECODE read of the same index in the same cycle returns the old value.
- Counters wrap 32'hFFFF_FFFF -> 0.

Optional Feature:
- CODE_BUF_EN defined:
  - Hold the last fetched code word and its address, valid bit cleared on reset.
  - In IDLE, a request whose code word address matches a valid buffer goes straight to DECODE using the buffered halfword; no CODE read.
  - The dictionary path then answers 2 cycles after accept.
  - Buffer updated on every completed CODE read, including aborted ones.
- Not defined: every request performs the CODE read; no buffer state exists.

Test Plan:
- Dict hit:
  - Setup: dict[5]=32'h0000_0013; code word @32'h0001_0000 = 32'h1234_8005.
  - Stimulus: req_addr=32'h0000_0000, zero-wait memory.
  - Required: one mem read at 32'h0001_0000; req_ready pulse 3 cycles after accept with req_rdata=32'h0000_0013; cnt_dict=1.
- Raw path:
  - Setup: code word @32'h0001_0000 upper half = 16'h0003; mem[32'h0002_000C]=32'hDEAD_BEEF.
  - Stimulus: req_addr=32'h0000_0004.
  - Required: reads at 32'h0001_0000 then 32'h0002_000C; req_rdata=32'hDEAD_BEEF; cnt_raw=1.
- Memory wait states:
  - Stimulus: mem_ready delayed 5 cycles on each read.
  - Required: mem_valid and mem_addr held constant throughout; correct data; exactly one req_ready pulse.
- Abort:
  - Stimulus: drop req_valid during CODE with mem_ready pending.
  - Required: read completes; no req_ready; counters unchanged; the next request is served normally.
- Async reset:
  - Stimulus: assert reset mid-RAW.
  - Required: mem_valid=0 and req_ready=0 immediately; counters=0; state IDLE after release.
- CODE_BUF_EN:
  - Stimulus: sequential requests 32'h0000_0000 then 32'h0000_0004, both dictionary entries.
  - Required: the second request issues no code read and answers 2 cycles after accept.

Source files
------------

// File: rtl/code_decomp_fill.sv
// Instruction-cache refill decompressor: expands 16-bit code-table entries from a
// dictionary or the raw-instruction region. Optional macro CODE_BUF_EN keeps the last code word.
module code_decomp_fill #(
    parameter int          DICT_BITS = 6,
    parameter logic [31:0] TEXT_BASE = 32'h0000_0000,
    parameter logic [31:0] CODE_BASE = 32'h0001_0000,
    parameter logic [31:0] RAW_BASE  = 32'h0002_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_addr,
    output logic [31:0]          req_rdata,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic [31:0]          mem_addr,
    input  logic [31:0]          mem_rdata,
    input  logic                 dict_we,
    input  logic [DICT_BITS-1:0] dict_waddr,
    input  logic [31:0]          dict_wdata,
    output logic [31:0]          cnt_dict,
    output logic [31:0]          cnt_raw
);

    typedef enum logic [2:0] {IDLE, CODE, DECODE, RAW, RESP} state_t;

    function automatic logic [31:0] word_idx(input logic [31:0] a);
        return (a - TEXT_BASE) >> 2;
    endfunction

    function automatic logic [31:0] code_addr(input logic [31:0] w);
        return CODE_BASE + ((w >> 1) << 2);
    endfunction

    function automatic logic [15:0] half_sel(input logic [31:0] word, input logic hi);
        return hi ? word[31:16] : word[15:0];
    endfunction

    logic [31:0] dict_mem [0:(1 << DICT_BITS) - 1];

    state_t      state_q, state_d;
    logic        sel_q, sel_d;
    logic [15:0] entry_q, entry_d;
    logic        abort_q, abort_d;
    logic        raw_q, raw_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] req_rdata_q, req_rdata_d;
    logic [31:0] cnt_dict_q, cnt_dict_d;
    logic [31:0] cnt_raw_q, cnt_raw_d;
    logic [31:0] req_w;
    logic        buf_hit;
    logic [31:0] buf_word;

`ifdef CODE_BUF_EN
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_addr_q, buf_addr_d;
    logic [31:0] buf_data_q, buf_data_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
        end
    end

    assign buf_hit  = buf_valid_q && (buf_addr_q == code_addr(req_w));
    assign buf_word = buf_data_q;
`else
    assign buf_hit  = 1'b0;
    assign buf_word = '0;
`endif

    assign req_w = word_idx(req_addr);

    // Dictionary has no reset; a same-cycle DECODE read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (dict_we) begin
            dict_mem[dict_waddr] <= dict_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        entry_d     = entry_q;
        abort_d     = abort_q;
        raw_d       = raw_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        req_rdata_d = req_rdata_q;
        cnt_dict_d  = cnt_dict_q;
        cnt_raw_d   = cnt_raw_q;
`ifdef CODE_BUF_EN
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
`endif
        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (req_valid) begin
                    sel_d = req_w[0];
                    if (buf_hit) begin
                        entry_d = half_sel(buf_word, req_w[0]);
                        state_d = DECODE;
                    end else begin
                        mem_addr_d  = code_addr(req_w);
                        mem_valid_d = 1'b1;
                        state_d     = CODE;
                    end
                end
            end
            CODE: begin
                // Once the requester drops, the read still completes but its data is discarded.
                if (!req_valid) abort_d = 1'b1;
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
`ifdef CODE_BUF_EN
                    buf_valid_d = 1'b1;
                    buf_addr_d  = mem_addr_q;
                    buf_data_d  = mem_rdata;
`endif
                    if (abort_q || !req_valid) begin
                        state_d = IDLE;
                    end else begin
                        entry_d = half_sel(mem_rdata, sel_q);
                        state_d = DECODE;
                    end
                end
            end
            DECODE: begin
                if (!req_valid) begin
                    state_d = IDLE;
                end else if (entry_q[15]) begin
                    req_rdata_d = dict_mem[entry_q[DICT_BITS-1:0]];
                    raw_d       = 1'b0;
                    state_d     = RESP;
                end else begin
                    mem_addr_d  = RAW_BASE + {15'd0, entry_q[14:0], 2'b00};
                    mem_valid_d = 1'b1;
                    state_d     = RAW;
                end
            end
            RAW: begin
                if (!req_valid) abort_d = 1'b1;
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    if (abort_q || !req_valid) begin
                        state_d = IDLE;
                    end else begin
                        req_rdata_d = mem_rdata;
                        raw_d       = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            RESP: begin
                if (raw_q) cnt_raw_d  = cnt_raw_q + 32'd1;
                else       cnt_dict_d = cnt_dict_q + 32'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            entry_q     <= '0;
            abort_q     <= 1'b0;
            raw_q       <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            req_rdata_q <= '0;
            cnt_dict_q  <= '0;
            cnt_raw_q   <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            entry_q     <= entry_d;
            abort_q     <= abort_d;
            raw_q       <= raw_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            req_rdata_q <= req_rdata_d;
            cnt_dict_q  <= cnt_dict_d;
            cnt_raw_q   <= cnt_raw_d;
        end
    end

    assign req_ready = (state_q == RESP);
    assign req_rdata = req_rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign cnt_dict  = cnt_dict_q;
    assign cnt_raw   = cnt_raw_q;

endmodule

// File: tb/tb_code_decomp_fill.sv
// Scoreboard bench for code_decomp_fill: directed requests, memory model with wait states,
// abort and asynchronous reset; buffer-aware expectations when CODE_BUF_EN is defined.
module tb_code_decomp_fill;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_rdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        dict_we;
    logic [5:0]  dict_waddr;
    logic [31:0] dict_wdata;
    logic [31:0] cnt_dict;
    logic [31:0] cnt_raw;

    code_decomp_fill dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_rdata(req_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .dict_we(dict_we), .dict_waddr(dict_waddr), .dict_wdata(dict_wdata),
        .cnt_dict(cnt_dict), .cnt_raw(cnt_raw)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] exp_data_q [$];
    int          exp_cyc_q [$];
    logic [31:0] exp_maddr_q [$];
    int          mem_wait = 0;
    logic [31:0] exp_cnt_dict = 0;
    logic [31:0] exp_cnt_raw = 0;
    bit          buf_v = 0;
    logic [31:0] buf_a = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Memory model: pops the expected address on the first valid cycle, then checks stability.
    bit          mbusy = 0;
    int          mcnt = 0;
    logic [31:0] mhold = 0;
    always @(negedge clk) begin
        if (reset) begin
            mem_ready = 1'b0;
            mbusy = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
            mbusy = 0;
        end else if (mem_valid) begin
            if (!mbusy) begin
                mbusy = 1;
                mcnt = 0;
                mhold = mem_addr;
                if (exp_maddr_q.size() == 0) fail_evt("mem_unexpected_read");
                else chk("mem_addr", mem_addr, exp_maddr_q.pop_front());
            end else begin
                chk("mem_addr_stable", mem_addr, mhold);
            end
            if (mcnt == mem_wait) begin
                mem_ready = 1'b1;
                mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
            end else begin
                mcnt++;
            end
        end else if (mbusy) begin
            fail_evt("mem_valid_dropped");
            mbusy = 0;
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (!reset && req_ready) begin
            if (exp_data_q.size() == 0) begin
                fail_evt("unexpected_req_ready");
            end else begin
                chk("req_rdata", req_rdata, exp_data_q.pop_front());
                chk("resp_cycle", cyc, exp_cyc_q.pop_front());
            end
        end
    end

    task automatic dict_write(input logic [5:0] idx, input logic [31:0] data);
        @(negedge clk);
        dict_we = 1'b1; dict_waddr = idx; dict_wdata = data;
        @(negedge clk);
        dict_we = 1'b0;
    endtask

    // Drives a request and queues its expected memory reads and (optionally) response.
    task automatic start_req(input logic [31:0] addr, input logic [31:0] ca, input bit raw,
                             input logic [31:0] ra, input logic [31:0] data, input int wt,
                             input bit resp);
        bit hit;
        int lat;
`ifdef CODE_BUF_EN
        hit = buf_v && (buf_a == ca);
`else
        hit = 0;
`endif
        lat = (hit ? 2 : 3 + wt) + (raw ? 1 + wt : 0);
        if (!hit) begin
            exp_maddr_q.push_back(ca);
            buf_v = 1;
            buf_a = ca;
        end
        if (raw) exp_maddr_q.push_back(ra);
        mem_wait = wt;
        @(negedge clk);
        req_addr = addr;
        req_valid = 1'b1;
        if (resp) begin
            exp_data_q.push_back(data);
            exp_cyc_q.push_back(cyc + lat);
        end
    endtask

    task automatic do_req(input logic [31:0] addr, input logic [31:0] ca, input bit raw,
                          input logic [31:0] ra, input logic [31:0] data, input int wt);
        bit seen = 0;
        start_req(addr, ca, raw, ra, data, wt, 1'b1);
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = req_ready;
        end
        if (!seen) fail_evt("req_ready_timeout");
        req_valid = 1'b0;
        if (raw) exp_cnt_raw++;
        else     exp_cnt_dict++;
        @(negedge clk);
        chk("cnt_dict", cnt_dict, exp_cnt_dict);
        chk("cnt_raw", cnt_raw, exp_cnt_raw);
    endtask

    initial begin
        bit found;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        dict_we = 1'b0; dict_waddr = '0; dict_wdata = '0;
        mem_model[32'h0001_0000] = 32'h0003_8005;
        mem_model[32'h0001_0004] = 32'h8007_0010;
        mem_model[32'h0001_000C] = 32'h8009_8008;
        mem_model[32'h0002_000C] = 32'hDEAD_BEEF;
        mem_model[32'h0002_0040] = 32'hCAFE_F00D;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_req_rdata", req_rdata, 32'd0);
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_cnt_dict", cnt_dict, 32'd0);
        chk("rst_cnt_raw", cnt_raw, 32'd0);
        reset = 1'b0;

        dict_write(6'd5, 32'h0000_0013);
        dict_write(6'd7, 32'h1111_2222);
        dict_write(6'd8, 32'hA5A5_0008);
        dict_write(6'd9, 32'h5A5A_0009);

        do_req(32'h0000_0000, 32'h0001_0000, 0, 32'h0, 32'h0000_0013, 0);
        do_req(32'h0000_0004, 32'h0001_0000, 1, 32'h0002_000C, 32'hDEAD_BEEF, 0);
        do_req(32'h0000_0008, 32'h0001_0004, 1, 32'h0002_0040, 32'hCAFE_F00D, 5);
        do_req(32'h0000_000C, 32'h0001_0004, 0, 32'h0, 32'h1111_2222, 5);

        // Abort while the code read is still waiting.
        start_req(32'h0000_0010, 32'h0001_0008, 0, 32'h0, 32'h0, 5, 1'b0);
        repeat (2) @(negedge clk);
        req_valid = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_cnt_dict", cnt_dict, exp_cnt_dict);
        chk("abort_cnt_raw", cnt_raw, exp_cnt_raw);
        chk("abort_mem_valid", {31'd0, mem_valid}, 32'd0);
        do_req(32'h0000_0000, 32'h0001_0000, 0, 32'h0, 32'h0000_0013, 0);

        // Sequential requests sharing one code word.
        do_req(32'h0000_0018, 32'h0001_000C, 0, 32'h0, 32'hA5A5_0008, 0);
        do_req(32'h0000_001C, 32'h0001_000C, 0, 32'h0, 32'h5A5A_0009, 0);

        // Asynchronous reset in the middle of a raw read.
        start_req(32'h0000_0004, 32'h0001_0000, 1, 32'h0002_000C, 32'h0, 5, 1'b0);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = mem_valid && (mem_addr == 32'h0002_000C);
        end
        if (!found) fail_evt("raw_phase_timeout");
        #2 reset = 1'b1;
        #1;
        chk("areset_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("areset_req_ready", {31'd0, req_ready}, 32'd0);
        chk("areset_cnt_dict", cnt_dict, 32'd0);
        chk("areset_cnt_raw", cnt_raw, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_cnt_dict = 0;
        exp_cnt_raw = 0;
        buf_v = 0;
        do_req(32'h0000_0000, 32'h0001_0000, 0, 32'h0, 32'h0000_0013, 0);

        repeat (4) @(negedge clk);
        chk("pending_responses", exp_data_q.size(), 32'd0);
        chk("pending_mem_reads", exp_maddr_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
